qoi_dma: RTL and testbench

Bus-master sequencer that streams a raw RGBA image from shared memory through the `qoi` encoder peripheral and writes the encoded byte stream back to memory, freeing the 6502 from per-byte polling. The CPU programs source, destination and pixel count through a small 8-register window, sets start, and polls or waits for done. The block owns the encoder's register port (`cs`/`we`/`addr`/`data`) and shares a single-port memory with the CPU through a request/grant handshake.

---
 rtl/qoi_dma_pkg.sv | 43 ++++
 rtl/qoi_dma_regs.sv | 119 +++++++++++
 rtl/qoi_dma.sv | 245 ++++++++++++++++++++++++
 tb/tb_qoi_dma.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qoi_dma_pkg.sv
// Shared types and constants for the QOI DMA sequencer: FSM states,
// encoder register map, encoder status bits and the CPU register window.
package qoi_dma_pkg;

    typedef logic [2:0] addr_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG,
        S_POLL,
        S_FETCH,
        S_PUSH,
        S_PULL,
        S_STORE,
        S_MARKER,
        S_DONE
    } dma_state_t;

    // Encoder register offsets and status bits
    localparam addr_t ENC_DATA = 3'd0;
    localparam addr_t ENC_CTRL = 3'd3;
    localparam addr_t ENC_SIZE = 3'd4;
    localparam int R_FLAG  = 0;
    localparam int W_FLAG  = 1;
    localparam int WORKING = 7;
    localparam logic [7:0] ENC_START = 8'h80;

    // CPU register window
    localparam addr_t REG_CTRL    = 3'd0;
    localparam addr_t REG_SRC_LO  = 3'd1;
    localparam addr_t REG_SRC_HI  = 3'd2;
    localparam addr_t REG_DST_LO  = 3'd3;
    localparam addr_t REG_DST_HI  = 3'd4;
    localparam addr_t REG_NPIX_LO = 3'd5;
    localparam addr_t REG_NPIX_HI = 3'd6;
    localparam addr_t REG_LAST    = 3'd7;

    localparam int CTRL_START   = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_MARKER  = 2;
    localparam int CTRL_IRQ_CLR = 3;

endpackage

// File: rtl/qoi_dma_regs.sv
// CPU-visible register file of the QOI DMA: pointers, pixel counters,
// status flags and the level interrupt. Sequencing lives in qoi_dma.
module qoi_dma_regs
    import qoi_dma_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  addr_t             addr,
    input  logic [7:0]        data_i,
    output logic [7:0]        data_o,
    output logic              irq,
    input  logic              busy,
    input  logic              src_inc,
    input  logic              dst_inc,
    input  logic              rem_dec,
    input  logic              last_we,
    input  logic [7:0]        last_d,
    input  logic              fin,
    input  logic              fin_err,
    input  logic              fin_abort,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [15:0]       npix,
    output logic [15:0]       remaining,
    output logic [7:0]        last,
    output logic              marker_en,
    output logic              start,
    output logic              abort,
    output logic              irq_clr
);

    logic [ADDR_W-1:0] src_reg, dst_reg;
    logic [15:0]       npix_reg, rem_reg, src16, dst16;
    logic [7:0]        last_reg;
    logic              marker_reg, done_reg, err_reg, abt_reg;
    logic              ctrl_wr, cfg_wr;

    assign src16   = 16'(src_reg);
    assign dst16   = 16'(dst_reg);
    assign ctrl_wr = cs && we && (addr == REG_CTRL);
    assign cfg_wr  = cs && we && !busy;

    // Abort takes precedence over a start carried in the same write
    assign start     = ctrl_wr && !busy && data_i[CTRL_START] && !data_i[CTRL_ABORT];
    assign abort     = ctrl_wr && busy && data_i[CTRL_ABORT];
    assign irq_clr   = ctrl_wr && data_i[CTRL_IRQ_CLR];
    // Forwarded so a start write sees the marker_en bit it carries
    assign marker_en = (ctrl_wr && !busy) ? data_i[CTRL_MARKER] : marker_reg;

    assign src       = src_reg;
    assign dst       = dst_reg;
    assign npix      = npix_reg;
    assign remaining = rem_reg;
    assign last      = last_reg;
    assign irq       = done_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_reg    <= '0;
            dst_reg    <= '0;
            npix_reg   <= '0;
            rem_reg    <= '0;
            last_reg   <= '0;
            marker_reg <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            abt_reg    <= 1'b0;
        end else begin
            if (cfg_wr) begin
                case (addr)
                    REG_CTRL:    marker_reg     <= data_i[CTRL_MARKER];
                    REG_SRC_LO:  src_reg        <= ADDR_W'({src16[15:8], data_i});
                    REG_SRC_HI:  src_reg        <= ADDR_W'({data_i, src16[7:0]});
                    REG_DST_LO:  dst_reg        <= ADDR_W'({dst16[15:8], data_i});
                    REG_DST_HI:  dst_reg        <= ADDR_W'({data_i, dst16[7:0]});
                    REG_NPIX_LO: npix_reg[7:0]  <= data_i;
                    REG_NPIX_HI: npix_reg[15:8] <= data_i;
                    default: ;
                endcase
            end
            if (src_inc) src_reg <= src_reg + 1'b1;
            if (dst_inc) dst_reg <= dst_reg + 1'b1;
            if (last_we) last_reg <= last_d;
            if (start) begin
                done_reg <= 1'b0;
                err_reg  <= 1'b0;
                abt_reg  <= 1'b0;
                rem_reg  <= npix_reg;
            end
            if (rem_dec) rem_reg <= rem_reg - 1'b1;
            if (irq_clr) done_reg <= 1'b0;
            // A zero-length start finishes in the same cycle, so fin wins
            if (fin) begin
                done_reg <= 1'b1;
                err_reg  <= fin_err;
                abt_reg  <= fin_abort;
            end
        end
    end

    always_comb begin
        data_o = 8'h00;
        case (addr)
            REG_CTRL:    data_o = {4'b0000, abt_reg, err_reg, done_reg, busy};
            REG_SRC_LO:  data_o = src16[7:0];
            REG_SRC_HI:  data_o = src16[15:8];
            REG_DST_LO:  data_o = dst16[7:0];
            REG_DST_HI:  data_o = dst16[15:8];
            REG_NPIX_LO: data_o = npix_reg[7:0];
            REG_NPIX_HI: data_o = npix_reg[15:8];
            default:     data_o = last_reg;
        endcase
    end

endmodule

// File: rtl/qoi_dma.sv
// QOI DMA sequencer: feeds RGBA bytes from memory into the qoi encoder and
// stores the encoded stream back to memory over a req/gnt port.
module qoi_dma
    import qoi_dma_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  addr_t             addr,
    input  logic [7:0]        data_i,
    output logic [7:0]        data_o,
    output logic              irq,
    output logic              enc_cs,
    output logic              enc_we,
    output addr_t             enc_addr,
    output logic [7:0]        enc_wdata,
    input  logic [7:0]        enc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_rdata
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    dma_state_t        state_reg, state_next;
    logic [2:0]        idx_reg, idx_next;
    logic              rd_pend_reg, rd_pend_next;
    logic [7:0]        byte_reg, byte_next;
    logic [TW-1:0]     to_reg, to_next;

    logic              busy, src_inc, dst_inc, rem_dec, last_we;
    logic              fin, fin_err, fin_abort;
    logic              marker_en, start, abort, irq_clr;
    logic [ADDR_W-1:0] src, dst;
    logic [15:0]       npix, remaining;
    logic [7:0]        last;

    assign busy = (state_reg != S_IDLE) && (state_reg != S_DONE);

    qoi_dma_regs #(.ADDR_W(ADDR_W)) u_regs (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .we        (we),
        .addr      (addr),
        .data_i    (data_i),
        .data_o    (data_o),
        .irq       (irq),
        .busy      (busy),
        .src_inc   (src_inc),
        .dst_inc   (dst_inc),
        .rem_dec   (rem_dec),
        .last_we   (last_we),
        .last_d    (enc_rdata),
        .fin       (fin),
        .fin_err   (fin_err),
        .fin_abort (fin_abort),
        .src       (src),
        .dst       (dst),
        .npix      (npix),
        .remaining (remaining),
        .last      (last),
        .marker_en (marker_en),
        .start     (start),
        .abort     (abort),
        .irq_clr   (irq_clr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            idx_reg     <= '0;
            rd_pend_reg <= 1'b0;
            byte_reg    <= '0;
            to_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            rd_pend_reg <= rd_pend_next;
            byte_reg    <= byte_next;
            to_reg      <= to_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        rd_pend_next = rd_pend_reg;
        byte_next    = byte_reg;
        to_next      = '0;
        enc_cs       = 1'b0;
        enc_we       = 1'b0;
        enc_addr     = ENC_DATA;
        enc_wdata    = 8'h00;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = 8'h00;
        src_inc      = 1'b0;
        dst_inc      = 1'b0;
        rem_dec      = 1'b0;
        last_we      = 1'b0;
        fin          = 1'b0;
        fin_err      = 1'b0;
        fin_abort    = 1'b0;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_next = '0;
                    if (npix != 16'd0) state_next = S_CFG;
                    else if (marker_en) state_next = S_MARKER;
                    else begin
                        state_next = S_DONE;
                        fin        = 1'b1;
                    end
                end else if (state_reg == S_DONE && irq_clr) begin
                    state_next = S_IDLE;
                end
            end
            S_CFG: begin
                // Size bytes little-endian at 4..7 (upper half zero), then go
                enc_cs   = 1'b1;
                enc_we   = 1'b1;
                enc_addr = (idx_reg == 3'd4) ? ENC_CTRL : ENC_SIZE + idx_reg;
                case (idx_reg)
                    3'd0:    enc_wdata = npix[7:0];
                    3'd1:    enc_wdata = npix[15:8];
                    3'd4:    enc_wdata = ENC_START;
                    default: enc_wdata = 8'h00;
                endcase
                if (idx_reg == 3'd4) begin
                    state_next = S_POLL;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 3'd1;
                end
            end
            S_POLL: begin
                enc_cs   = 1'b1;
                enc_addr = ENC_CTRL;
                if (enc_rdata[W_FLAG]) begin
                    state_next = S_PULL;
                end else if (enc_rdata[R_FLAG]) begin
                    idx_next = '0;
                    if (remaining != 16'd0) begin
                        state_next   = S_FETCH;
                        rd_pend_next = 1'b0;
                    end else if (marker_en) begin
                        state_next = S_MARKER;
                    end else begin
                        state_next = S_DONE;
                        fin        = 1'b1;
                    end
                end else if (to_reg == TO_LAST) begin
                    state_next = S_DONE;
                    fin        = 1'b1;
                    fin_err    = 1'b1;
                end else begin
                    to_next = to_reg + 1'b1;
                end
            end
            S_FETCH: begin
                if (rd_pend_reg) begin
                    byte_next    = mem_rdata;
                    rd_pend_next = 1'b0;
                    state_next   = S_PUSH;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = src;
                    if (mem_gnt) begin
                        src_inc      = 1'b1;
                        rd_pend_next = 1'b1;
                    end
                end
            end
            S_PUSH: begin
                enc_cs    = 1'b1;
                enc_we    = 1'b1;
                enc_wdata = byte_reg;
                if (idx_reg == 3'd3) begin
                    rem_dec    = 1'b1;
                    idx_next   = '0;
                    state_next = S_POLL;
                end else begin
                    idx_next   = idx_reg + 3'd1;
                    state_next = S_FETCH;
                end
            end
            S_PULL: begin
                enc_cs     = 1'b1;
                last_we    = 1'b1;
                state_next = S_STORE;
            end
            S_STORE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst;
                mem_wdata = last;
                if (mem_gnt) begin
                    dst_inc    = 1'b1;
                    state_next = S_POLL;
                end
            end
            S_MARKER: begin
                // End-of-stream marker: seven 0x00 bytes followed by 0x01
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst;
                mem_wdata = (idx_reg == 3'd7) ? 8'h01 : 8'h00;
                if (mem_gnt) begin
                    dst_inc = 1'b1;
                    if (idx_reg == 3'd7) begin
                        state_next = S_DONE;
                        fin        = 1'b1;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Abort cancels any bookkeeping of the current cycle
        if (abort) begin
            state_next = S_DONE;
            src_inc    = 1'b0;
            dst_inc    = 1'b0;
            rem_dec    = 1'b0;
            last_we    = 1'b0;
            fin        = 1'b1;
            fin_err    = 1'b0;
            fin_abort  = 1'b1;
        end
    end

endmodule

// File: tb/tb_qoi_dma.sv
// Directed bench for qoi_dma with a simple encoder stand-in (two output
// bytes per pixel: byte sum, pixel number) and a req/gnt memory model.
module tb_qoi_dma;
    import qoi_dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, we = 1'b0;
    addr_t       addr = 3'd0;
    logic [7:0]  data_i = 8'h00;
    logic [7:0]  data_o;
    logic        irq;
    logic        enc_cs, enc_we;
    addr_t       enc_addr;
    logic [7:0]  enc_wdata, enc_rdata;
    logic        mem_req, mem_we, mem_gnt;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    qoi_dma #(.ADDR_W(16), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr),
        .data_i(data_i), .data_o(data_o), .irq(irq),
        .enc_cs(enc_cs), .enc_we(enc_we), .enc_addr(enc_addr),
        .enc_wdata(enc_wdata), .enc_rdata(enc_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad = 0;

    // bench controls
    logic       tb_clr = 1'b0;
    logic       enc_dead = 1'b0;
    logic       gnt_rand = 1'b0;
    logic [7:0] pat [0:3];

    // encoder stand-in state
    logic        enc_started;
    logic [7:0]  oq [0:15];
    logic [3:0]  oq_head, oq_tail;
    logic [7:0]  psum, enc_pix, ctrl_val;
    logic [1:0]  bcnt;
    logic [31:0] size_v;
    logic [7:0]  dlog [0:3];
    int          data_writes, poll_cnt, enc_access, b2b;
    logic        prev_a0 = 1'b0;

    always_comb begin
        enc_rdata = 8'h00;
        if (!enc_dead) begin
            if (enc_addr == 3'd3)
                enc_rdata = {enc_started, 5'b00000, oq_head != oq_tail,
                             enc_started && (oq_head == oq_tail)};
            else if (enc_addr == 3'd0)
                enc_rdata = oq[oq_head];
        end
    end

    always @(posedge clk) begin
        if (tb_clr) begin
            enc_started <= 1'b0; oq_head <= '0; oq_tail <= '0;
            psum <= '0; enc_pix <= '0; ctrl_val <= '0; bcnt <= '0; size_v <= '0;
            data_writes <= 0; poll_cnt <= 0; enc_access <= 0; b2b <= 0;
        end else begin
            if (enc_cs) enc_access <= enc_access + 1;
            if (enc_cs && !enc_we && enc_addr == 3'd3) poll_cnt <= poll_cnt + 1;
            if (enc_cs && enc_addr == 3'd0 && prev_a0) b2b <= b2b + 1;
            if (enc_cs && enc_we) begin
                case (enc_addr)
                    3'd0: begin
                        if (data_writes < 4) dlog[data_writes] <= enc_wdata;
                        data_writes <= data_writes + 1;
                        if (bcnt == 2'd3) begin
                            oq[oq_tail]        <= psum + enc_wdata;
                            oq[oq_tail + 4'd1] <= enc_pix + 8'd1;
                            oq_tail <= oq_tail + 4'd2;
                            enc_pix <= enc_pix + 8'd1;
                            psum    <= 8'h00;
                        end else begin
                            psum <= psum + enc_wdata;
                        end
                        bcnt <= bcnt + 2'd1;
                    end
                    3'd3: begin ctrl_val <= enc_wdata; enc_started <= enc_wdata[7]; end
                    3'd4: size_v[7:0]   <= enc_wdata;
                    3'd5: size_v[15:8]  <= enc_wdata;
                    3'd6: size_v[23:16] <= enc_wdata;
                    3'd7: size_v[31:24] <= enc_wdata;
                    default: ;
                endcase
            end
            if (enc_cs && !enc_we && enc_addr == 3'd0 && oq_head != oq_tail)
                oq_head <= oq_head + 4'd1;
        end
        prev_a0 <= enc_cs && enc_addr == 3'd0;
    end

    // memory model: reads come from the repeating pixel pattern
    logic [7:0]  mem [0:65535];
    logic [7:0]  rdata_q = 8'h00;
    logic        hold_v = 1'b0, hold_we = 1'b0;
    logic [15:0] hold_a = '0;
    logic [7:0]  hold_wd = '0;
    int          unstable = 0;
    assign mem_rdata = rdata_q;

    always @(negedge clk) mem_gnt <= gnt_rand ? ($urandom_range(0, 9) < 3) : 1'b1;

    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        rdata_q <= pat[mem_addr[1:0]];
        end
        if (hold_v && mem_req &&
            (mem_addr != hold_a || mem_we != hold_we || mem_wdata != hold_wd))
            unstable <= unstable + 1;
        hold_v  <= mem_req && !mem_gnt;
        hold_a  <= mem_addr;
        hold_we <= mem_we;
        hold_wd <= mem_wdata;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", nm, act);
        end
    endtask

    task automatic wr(input addr_t a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; data_i = d;
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0; data_i = 8'h00;
    endtask

    task automatic rd(input addr_t a, output logic [7:0] v);
        @(negedge clk);
        addr = a;
        #1 v = data_o;
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        wr(REG_SRC_LO, s[7:0]);  wr(REG_SRC_HI, s[15:8]);
        wr(REG_DST_LO, d[7:0]);  wr(REG_DST_HI, d[15:8]);
        wr(REG_NPIX_LO, n[7:0]); wr(REG_NPIX_HI, n[15:8]);
    endtask

    task automatic clr_models();
        @(negedge clk); tb_clr = 1'b1;
        @(negedge clk); tb_clr = 1'b0;
    endtask

    task automatic wait_irq(input string nm, input int maxc);
        int n = 0;
        while (!irq && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(irq), 1);
    endtask

    typedef struct {
        bit         wr;
        addr_t      a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl [14];
    logic [7:0] v;
    logic [7:0] exp_b [0:13];

    initial begin
        tbl[0]  = '{1'b1, REG_SRC_LO,  8'h04, 8'h00};
        tbl[1]  = '{1'b1, REG_SRC_HI,  8'h01, 8'h00};
        tbl[2]  = '{1'b1, REG_DST_LO,  8'h10, 8'h00};
        tbl[3]  = '{1'b1, REG_DST_HI,  8'h02, 8'h00};
        tbl[4]  = '{1'b1, REG_NPIX_LO, 8'h01, 8'h00};
        tbl[5]  = '{1'b1, REG_NPIX_HI, 8'h00, 8'h00};
        tbl[6]  = '{1'b0, REG_SRC_LO,  8'h00, 8'h04};
        tbl[7]  = '{1'b0, REG_SRC_HI,  8'h00, 8'h01};
        tbl[8]  = '{1'b0, REG_DST_LO,  8'h00, 8'h10};
        tbl[9]  = '{1'b0, REG_DST_HI,  8'h00, 8'h02};
        tbl[10] = '{1'b0, REG_NPIX_LO, 8'h00, 8'h01};
        tbl[11] = '{1'b0, REG_NPIX_HI, 8'h00, 8'h00};
        tbl[12] = '{1'b0, REG_LAST,    8'h00, 8'h00};
        tbl[13] = '{1'b0, REG_CTRL,    8'h00, 8'h00};
        for (int i = 0; i < 6; i++) exp_b[i] = (i % 2 == 0) ? 8'h5F : 8'(i / 2 + 1);
        for (int i = 6; i < 14; i++) exp_b[i] = (i == 13) ? 8'h01 : 8'h00;

        // reset state
        tb_clr = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_enc_cs", int'(enc_cs), 0);
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_irq", int'(irq), 0);
        chk("rst_status", int'(data_o), 0);
        rst = 1'b0;
        tb_clr = 1'b0;

        // register window
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) wr(tbl[i].a, tbl[i].d);
            else begin
                rd(tbl[i].a, v);
                chk($sformatf("reg_rd%0d", tbl[i].a), int'(v), int'(tbl[i].exp));
            end
        end

        // one pixel, no marker
        pat[0] = 8'h00; pat[1] = 8'h00; pat[2] = 8'h00; pat[3] = 8'hFF;
        clr_models();
        wr(REG_CTRL, 8'h01);
        rd(REG_CTRL, v);
        chk("a_busy", int'(v), 8'h01);
        wait_irq("a_irq", 1000);
        chk("a_size", int'(size_v), 1);
        chk("a_ctrl", int'(ctrl_val), 8'h80);
        chk("a_nwrites", data_writes, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("a_data%0d", i), int'(dlog[i]), int'(pat[i]));
        chk("a_mem0", int'(mem[16'h0210]), 8'hFF);
        chk("a_mem1", int'(mem[16'h0211]), 8'h01);
        rd(REG_SRC_LO, v);  chk("a_src_lo", int'(v), 8'h08);
        rd(REG_DST_LO, v);  chk("a_dst_lo", int'(v), 8'h12);
        rd(REG_LAST, v);    chk("a_last", int'(v), 8'h01);
        rd(REG_CTRL, v);    chk("a_status", int'(v), 8'h02);
        wr(REG_CTRL, 8'h08);
        rd(REG_CTRL, v);    chk("a_clr_status", int'(v), 8'h00);
        chk("a_clr_irq", int'(irq), 0);

        // three identical pixels with end marker
        pat[0] = 8'h10; pat[1] = 8'h20; pat[2] = 8'h30; pat[3] = 8'hFF;
        clr_models();
        setup(16'h0300, 16'h0400, 16'd3);
        wr(REG_CTRL, 8'h05);
        wait_irq("b_irq", 2000);
        for (int i = 0; i < 14; i++)
            chk($sformatf("b_mem%0d", i), int'(mem[16'h0400 + 16'(i)]), int'(exp_b[i]));
        rd(REG_DST_LO, v);  chk("b_dst_len", int'(v), 8'h0E);
        chk("b_b2b_addr0", b2b, 0);

        // same job under random grants
        gnt_rand = 1'b1;
        clr_models();
        setup(16'h0300, 16'h0500, 16'd3);
        wr(REG_CTRL, 8'h05);
        wait_irq("c_irq", 5000);
        gnt_rand = 1'b0;
        for (int i = 0; i < 14; i++)
            chk($sformatf("c_mem%0d", i), int'(mem[16'h0500 + 16'(i)]), int'(exp_b[i]));
        chk("c_req_stable", unstable, 0);
        rd(REG_DST_HI, v);  chk("c_dst_hi", int'(v), 8'h05);

        // encoder that never raises a flag
        enc_dead = 1'b1;
        clr_models();
        setup(16'h0A00, 16'h0B00, 16'd1);
        wr(REG_CTRL, 8'h01);
        wait_irq("d_irq", 2000);
        chk("d_poll_cycles", poll_cnt, 255);
        chk("d_ctrl", int'(ctrl_val), 8'h80);
        rd(REG_CTRL, v);    chk("d_status", int'(v), 8'h06);
        enc_dead = 1'b0;

        // abort after two pixels, then a zero-length job
        clr_models();
        setup(16'h0600, 16'h0700, 16'd4);
        wr(REG_CTRL, 8'h01);
        wr(REG_NPIX_LO, 8'h99);
        begin
            int n = 0;
            while (data_writes < 8 && n < 1000) begin
                @(negedge clk);
                n++;
            end
        end
        chk("e_two_pixels", data_writes, 8);
        wr(REG_CTRL, 8'h03);
        addr = REG_CTRL;
        #1;
        chk("e_enc_cs", int'(enc_cs), 0);
        chk("e_mem_req", int'(mem_req), 0);
        chk("e_status", int'(data_o), 8'h0A);
        chk("e_irq", int'(irq), 1);
        rd(REG_NPIX_LO, v); chk("e_npix_kept", int'(v), 8'h04);
        clr_models();
        wr(REG_NPIX_LO, 8'h00);
        wr(REG_CTRL, 8'h01);
        repeat (3) @(negedge clk);
        chk("f_enc_access", enc_access, 0);
        rd(REG_CTRL, v);    chk("f_status", int'(v), 8'h02);

        // asynchronous reset during a fetch with grant high
        clr_models();
        setup(16'h0800, 16'h0900, 16'd1);
        wr(REG_CTRL, 8'h01);
        begin
            int n = 0;
            bit seen = 1'b0;
            while (!seen && n < 200) begin
                @(negedge clk);
                seen = mem_req && !mem_we;
                n++;
            end
            chk("g_fetch_seen", int'(seen), 1);
        end
        addr = REG_CTRL;
        rst = 1'b1;
        #1;
        chk("g_mem_req", int'(mem_req), 0);
        chk("g_enc_cs", int'(enc_cs), 0);
        chk("g_mem_addr", int'(mem_addr), 0);
        chk("g_status", int'(data_o), 0);
        addr = REG_SRC_HI;
        #1;
        chk("g_src_hi", int'(data_o), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
